// File: rtl/game_tick_pkg.sv
// Shared types and helpers for the game tick generator.
package game_tick_pkg;

    // Channel FSM states
    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Channel mode encoding as written through cfg_oneshot
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Width needed to index n items, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/game_tick_channel.sv
// One timer channel: period/mode registers, down-counter, IDLE/RUN FSM and
// a registered expiry pulse. Counts only on the shared 1 ms tick.
module game_tick_channel
    import game_tick_pkg::*;
#(
    parameter int PER_W          = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [PER_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    output logic             pulse,
    output logic             busy
);

    ch_state_t        state_reg,   state_next;
    logic [PER_W-1:0] cnt_reg,     cnt_next;
    logic [PER_W-1:0] period_reg,  period_next;
    logic             oneshot_reg, oneshot_next;
    logic             pulse_reg,   pulse_next;

    // Next-state logic. Loads read period_reg, so a same-cycle cfg write only
    // affects the following load; stop has priority over start and expiry.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        oneshot_next = oneshot_reg;
        pulse_next   = 1'b0;

        if (cfg_we) begin
            period_next  = cfg_period;
            oneshot_next = cfg_oneshot;
        end

        case (state_reg)
            CH_IDLE: begin
                if (start && !stop && (period_reg != '0)) begin
                    state_next = CH_RUN;
                    cnt_next   = period_reg;
                end
            end
            CH_RUN: begin
                if (stop) begin
                    state_next = CH_IDLE;
                end else if (start) begin
                    // Restart; a zero period cannot run, so it stops instead
                    if (period_reg == '0) begin
                        state_next = CH_IDLE;
                    end else begin
                        cnt_next = period_reg;
                    end
                end else if (tick) begin
                    if (cnt_reg == PER_W'(1)) begin
                        pulse_next = 1'b1;
                        if ((oneshot_reg == MODE_ONESHOT) || (period_reg == '0)) begin
                            state_next = CH_IDLE;
                        end else begin
                            cnt_next = period_reg;
                        end
                    end else begin
                        cnt_next = cnt_reg - PER_W'(1);
                    end
                end
            end
            default: state_next = CH_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CH_IDLE;
            cnt_reg     <= '0;
            period_reg  <= PER_W'(DEFAULT_PERIOD);
            oneshot_reg <= MODE_PERIODIC;
            pulse_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            period_reg  <= period_next;
            oneshot_reg <= oneshot_next;
            pulse_reg   <= pulse_next;
        end
    end

    assign pulse = pulse_reg;
    assign busy  = (state_reg == CH_RUN);

endmodule

// File: rtl/game_tick_gen.sv
// Game timing tick generator: shared 1 ms prescaler feeding NUM_CH
// independent programmable channels. en=0 pauses everything.
module game_tick_gen
    import game_tick_pkg::*;
#(
    parameter int CLK_PER_MS     = 50000,
    parameter int NUM_CH         = 4,
    parameter int PER_W          = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               cfg_we,
    input  logic [clog2_min1(NUM_CH)-1:0]      cfg_ch,
    input  logic [PER_W-1:0]                   cfg_period,
    input  logic                               cfg_oneshot,
    input  logic [NUM_CH-1:0]                  ch_start,
    input  logic [NUM_CH-1:0]                  ch_stop,
    output logic                               tick_ms,
    output logic [NUM_CH-1:0]                  ch_pulse,
    output logic [NUM_CH-1:0]                  ch_busy
);

    localparam int PS_W = clog2_min1(CLK_PER_MS);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic [PS_W-1:0]   ps_cnt_reg, ps_cnt_next;
    logic              ps_wrap;
    logic [NUM_CH-1:0] cfg_sel;

    assign ps_wrap = (ps_cnt_reg == PS_W'(CLK_PER_MS - 1));
    assign tick_ms = en && ps_wrap;

    // Prescaler next value: free-running 0..CLK_PER_MS-1 while enabled, held otherwise
    always_comb begin
        ps_cnt_next = ps_cnt_reg;
        if (en) begin
            ps_cnt_next = ps_wrap ? '0 : ps_cnt_reg + PS_W'(1);
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt_reg <= '0;
        end else begin
            ps_cnt_reg <= ps_cnt_next;
        end
    end

    // Per-channel cfg decode and channel instances; an out-of-range cfg_ch
    // matches no channel, so that write is dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign cfg_sel[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            game_tick_channel #(
                .PER_W          (PER_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .tick        (tick_ms),
                .start       (ch_start[gi]),
                .stop        (ch_stop[gi]),
                .cfg_we      (cfg_sel[gi]),
                .cfg_period  (cfg_period),
                .cfg_oneshot (cfg_oneshot),
                .pulse       (ch_pulse[gi]),
                .busy        (ch_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen (CLK_PER_MS=4, NUM_CH=2, PER_W=8, DEFAULT_PERIOD=7).
// Timing convention: channel starts are applied when the prescaler phase is 1,
// so tick k of a channel is sampled at step t=4k-2 after the start step t=0,
// and a channel of period P first pulses at t=4P-2.
module tb_game_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_we;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_period;
    logic       cfg_oneshot;
    logic [1:0] ch_start;
    logic [1:0] ch_stop;
    logic       tick_ms;
    logic [1:0] ch_pulse;
    logic [1:0] ch_busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int ps           = 0;   // bench's own view of the prescaler phase
    logic [4:0] obs_v, exp_v;

    game_tick_gen #(
        .CLK_PER_MS     (4),
        .NUM_CH         (2),
        .PER_W          (8),
        .DEFAULT_PERIOD (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .ch_start    (ch_start),
        .ch_stop     (ch_stop),
        .tick_ms     (tick_ms),
        .ch_pulse    (ch_pulse),
        .ch_busy     (ch_busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        if (rst) ps = 0;
        else if (en) ps = (ps + 1) % 4;
        #1;
    endtask

    // Step until the prescaler phase is 1 so a start lands at a known phase
    task automatic align();
        while (ps != 1) step();
    endtask

    task automatic write_cfg(input logic ch, input logic [7:0] per, input logic os);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_oneshot = os;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic start_ch(input logic [1:0] m);
        ch_start = m;
        step();
        ch_start = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_period = '0;
        cfg_oneshot = 1'b0; ch_start = 2'b11; ch_stop = 2'b00;
        step(); step();
        rst = 1'b0; ch_start = 2'b00;
        obs_v = {tick_ms, ch_pulse, ch_busy};
        tests_run++;
        if (obs_v !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 00000", obs_v);
        end
        step();
        obs_v = {tick_ms, ch_pulse, ch_busy};
        tests_run++;
        if (obs_v !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_start_ignored: got %b expected 00000", obs_v);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_prescaler();
        en = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            step();
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(t % 4 == 3), 4'b0000};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL prescaler t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        $display("[TB] test_prescaler done");
    endtask

    task automatic test_periodic();
        write_cfg(1'b0, 8'd3, 1'b0);
        align();
        start_ch(2'b01);
        tests_run++;
        if (ch_busy !== 2'b01) begin
            tests_failed++;
            $display("FAIL periodic_busy_rise: got %b expected 01", ch_busy);
        end
        for (int t = 1; t <= 36; t++) begin
            step();
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(ps == 3), 1'b0, (t == 10 || t == 22 || t == 34), 2'b01};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL periodic t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        ch_stop = 2'b01; step(); ch_stop = 2'b00;
        tests_run++;
        if (ch_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL periodic_stop: got %b expected 00", ch_busy);
        end
        $display("[TB] test_periodic done");
    endtask

    task automatic test_oneshot();
        write_cfg(1'b1, 8'd2, 1'b1);
        align();
        start_ch(2'b10);
        for (int t = 1; t <= 46; t++) begin
            step();
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(ps == 3), (t == 6), 1'b0, (t < 6), 1'b0};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL oneshot t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        $display("[TB] test_oneshot done");
    endtask

    task automatic test_pause();
        align();
        start_ch(2'b01);
        for (int t = 1; t <= 34; t++) begin
            en = !(t >= 5 && t <= 14);
            step();
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(en && ps == 3), 1'b0, (t == 20 || t == 32), 2'b01};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL pause t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        en = 1'b1;
        ch_stop = 2'b01; step(); ch_stop = 2'b00;
        $display("[TB] test_pause done");
    endtask

    task automatic test_start_stop_expiry();
        align();
        start_ch(2'b01);
        for (int t = 1; t <= 20; t++) begin
            if (t == 10) begin ch_start = 2'b01; ch_stop = 2'b01; end
            step();
            ch_start = 2'b00; ch_stop = 2'b00;
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(ps == 3), 2'b00, 1'b0, (t < 10)};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL start_stop_expiry t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        $display("[TB] test_start_stop_expiry done");
    endtask

    task automatic test_cfg_on_expiry();
        align();
        start_ch(2'b01);
        for (int t = 1; t <= 44; t++) begin
            if (t == 10) begin
                cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd5; cfg_oneshot = 1'b0;
            end
            step();
            cfg_we = 1'b0;
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(ps == 3), 1'b0, (t == 10 || t == 22 || t == 42), 2'b01};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL cfg_on_expiry t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        ch_stop = 2'b01; step(); ch_stop = 2'b00;
        $display("[TB] test_cfg_on_expiry done");
    endtask

    task automatic test_period_zero();
        // Period is 5 from the previous test: expiry at t=18
        align();
        start_ch(2'b01);
        for (int t = 1; t <= 30; t++) begin
            if (t == 3) begin
                cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd0; cfg_oneshot = 1'b0;
            end
            step();
            cfg_we = 1'b0;
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(ps == 3), 1'b0, (t == 18), 1'b0, (t < 18)};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL period_zero_stop t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        start_ch(2'b01);
        for (int t = 1; t <= 8; t++) begin
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(ps == 3), 4'b0000};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL period_zero_start t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
            step();
        end
        $display("[TB] test_period_zero done");
    endtask

    task automatic test_reset_mid();
        write_cfg(1'b0, 8'd3, 1'b0);
        start_ch(2'b11);
        for (int t = 0; t < 5; t++) step();
        rst = 1'b1; step(); rst = 1'b0;
        obs_v = {tick_ms, ch_pulse, ch_busy};
        tests_run++;
        if (obs_v !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %b expected 00000", obs_v);
        end
        // Both channels must be back to period 7, periodic
        align();
        start_ch(2'b11);
        for (int t = 1; t <= 30; t++) begin
            step();
            obs_v = {tick_ms, ch_pulse, ch_busy};
            exp_v = {(ps == 3), (t == 26) ? 2'b11 : 2'b00, 2'b11};
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_default_period t=%0d: got %b expected %b", t, obs_v, exp_v);
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_periodic();
        test_oneshot();
        test_pause();
        test_start_stop_expiry();
        test_cfg_on_expiry();
        test_period_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
